// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle for the seven-segment scan controller: frame data,
// load strobe and brightness in; segment/anode drives and frame marker out.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 3
);
    logic [5*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    load;
    logic                    frame_start;
    logic [7:0]              SEG;
    logic [NUM_DIGITS-1:0]   AN;

    // Board-level control logic drives frame data and observes the pins.
    modport master (
        output dig, dp, blink_en, brightness, load,
        input  frame_start, SEG, AN
    );

    // The scan controller consumes frame data and drives the pins.
    modport slave (
        input  dig, dp, blink_en, brightness, load,
        output frame_start, SEG, AN
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Cycles one digit at a time
// through NUM_DIGITS anodes, with per-digit decimal point and blink, PWM
// brightness, and a double-buffered frame that only swaps at frame wrap so
// a frame is never shown half old, half new.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 5000,
    parameter int BLINK_DIV  = 50000000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                  clk100MHZ,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [4:0]         CODE_BLANK = 5'd17;

    // Scan timing
    logic [PRESC_W-1:0]      presc_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    scan_tick;
    logic                    wrap_tick;

    // Brightness and blink timing
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;

    // Frame buffers
    logic [5*NUM_DIGITS-1:0] pend_dig;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blink;
    logic                    pend_flag;
    logic [5*NUM_DIGITS-1:0] act_dig;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blink;

    // Current-digit selection
    logic [4:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blink;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    digit_on;

    // Registered pin drives
    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_start_q;

    // Active-low {g,f,e,d,c,b,a} pattern for a 5-bit display code.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'd0:    seg_decode = 7'h40;
            5'd1:    seg_decode = 7'h79;
            5'd2:    seg_decode = 7'h24;
            5'd3:    seg_decode = 7'h30;
            5'd4:    seg_decode = 7'h19;
            5'd5:    seg_decode = 7'h12;
            5'd6:    seg_decode = 7'h02;
            5'd7:    seg_decode = 7'h78;
            5'd8:    seg_decode = 7'h00;
            5'd9:    seg_decode = 7'h10;
            5'd10:   seg_decode = 7'h08;
            5'd11:   seg_decode = 7'h03;
            5'd12:   seg_decode = 7'h46;
            5'd13:   seg_decode = 7'h21;
            5'd14:   seg_decode = 7'h06;
            5'd15:   seg_decode = 7'h0E;
            5'd16:   seg_decode = 7'h3F;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign scan_tick = (presc_cnt == PRESC_LAST);
    assign wrap_tick = scan_tick && (idx == IDX_LAST);

    // Prescaler and digit index: one slot of SCAN_DIV cycles per digit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the same pre-edge values.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            idx       <= '0;
        end else if (scan_tick) begin
            presc_cnt <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // Frame marker: one cycle, the cycle after the index wraps.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) frame_start_q <= 1'b0;
        else        frame_start_q <= wrap_tick;
    end

    // Free-running PWM phase; wraps naturally at 2^BRIGHT_W.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
    end

    // Blink half-period counter; phase flips each time it wraps.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // Pending frame capture; the latest load in a frame overwrites earlier ones.
    // NOTE: the pending buffer is not reset; it is only read while pend_flag
    // is set, and pend_flag itself is reset.
    always_ff @(posedge clk100MHZ) begin
        if (bus.load) begin
            pend_dig   <= bus.dig;
            pend_dp    <= bus.dp;
            pend_blink <= bus.blink_en;
        end
    end

    // Pending flag: raised by load, consumed at frame wrap (wrap wins).
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n)         pend_flag <= 1'b0;
        else if (wrap_tick) pend_flag <= 1'b0;
        else if (bus.load)  pend_flag <= 1'b1;
    end

    // Active frame: only changes on the wrapping tick; a load in that very
    // cycle bypasses the pending copy so the newest data is shown at once.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            act_dig   <= {NUM_DIGITS{CODE_BLANK}};
            act_dp    <= '0;
            act_blink <= '0;
        end else if (wrap_tick) begin
            if (bus.load) begin
                act_dig   <= bus.dig;
                act_dp    <= bus.dp;
                act_blink <= bus.blink_en;
            end else if (pend_flag) begin
                act_dig   <= pend_dig;
                act_dp    <= pend_dp;
                act_blink <= pend_blink;
            end
        end
    end

    // Select the current digit's code, dp and blink bit plus its anode mask.
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        cur_code  = CODE_BLANK;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = act_dig[5*i +: 5];
                cur_dp    = act_dp[i];
                cur_blink = act_blink[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    // Digit is lit when inside its PWM duty window and not blinked off.
    assign digit_on = (pwm_cnt <= bus.brightness) && !(blink_phase && cur_blink);

    // Pin registers: anode and segments update together from the same index,
    // so a digit change never shows the previous digit's pattern.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else if (digit_on) begin
            seg_q <= {~cur_dp, seg_decode(cur_code)};
            an_q  <= an_sel;
        end else begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end
    end

    assign bus.SEG         = seg_q;
    assign bus.AN          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with 4 digits, 4-cycle slots, 32-cycle
// blink half-period. Stimulus runs frame-synchronously and queues the
// expected per-frame summary; the monitor rebuilds that summary from the
// pins over each 16-cycle frame and compares.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 32;
    localparam int BW = 3;

    typedef struct packed {
        logic [19:0] dig;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } ld_t;

    // seg: {d3,d2,d1,d0} lit pattern; lit: {d3,d2,d1,d0} lit-cycle counts
    typedef struct packed {
        logic [31:0] seg;
        logic [15:0] lit;
    } exp_t;

    typedef struct packed {
        logic [2:0] br;
        logic [3:0] ja;
        ld_t        da;
        logic [3:0] jb;
        ld_t        db;
        exp_t       ex;
    } row_t;

    logic clk100MHZ = 1'b0;
    logic rst_n;

    always #5 clk100MHZ = ~clk100MHZ;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .BRIGHT_W(BW)
    ) dut (
        .clk100MHZ(clk100MHZ),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    row_t rows[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ld_t uni(input logic [4:0] c, input logic [3:0] dp, input logic [3:0] bl);
        ld_t d;
        d.dig = {4{c}};
        d.dp  = dp;
        d.bl  = bl;
        return d;
    endfunction

    function automatic row_t mk(input logic [2:0] br, input int ja, input ld_t da,
                                input int jb, input ld_t db,
                                input logic [31:0] seg, input logic [15:0] lit);
        row_t r;
        r.br     = br;
        r.ja     = 4'(ja);
        r.da     = da;
        r.jb     = 4'(jb);
        r.db     = db;
        r.ex.seg = seg;
        r.ex.lit = lit;
        return r;
    endfunction

    // ---------------- monitor ----------------
    bit         collecting = 1'b0;
    int         samp;
    int         fnum = 0;
    int         lit[4];
    logic [7:0] segc[4];
    bit         shape_bad;

    always @(negedge clk100MHZ) begin
        if (!rst_n) begin
            collecting = 1'b0;
        end else if (!collecting) begin
            if (bus.frame_start === 1'b1) begin
                collecting = 1'b1;
                samp = 0; shape_bad = 1'b0;
                for (int d = 0; d < 4; d++) begin lit[d] = 0; segc[d] = 8'hFF; end
            end
        end else begin
            int         slot;
            logic [3:0] one_hot;
            slot    = samp / 4;
            one_hot = 4'b0001 << slot;
            if (bus.AN === 4'hF) begin
                if (bus.SEG !== 8'hFF) shape_bad = 1'b1;
            end else if (bus.AN !== ~one_hot) begin
                shape_bad = 1'b1;
            end else begin
                if (lit[slot] == 0) segc[slot] = bus.SEG;
                else if (segc[slot] !== bus.SEG) shape_bad = 1'b1;
                lit[slot]++;
            end
            if ((samp == 15) != (bus.frame_start === 1'b1)) shape_bad = 1'b1;
            samp++;
            if (samp == 16) begin
                fnum++;
                check($sformatf("frame%0d_shape", fnum), 64'(shape_bad), 64'd0);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    for (int d = 0; d < 4; d++) begin
                        logic [3:0] el;
                        logic [7:0] es;
                        el = e.lit[4*d +: 4];
                        es = e.seg[8*d +: 8];
                        check($sformatf("frame%0d_digit%0d", fnum, d),
                              {48'd0, 8'(lit[d]), (el == 4'd0) ? 8'h00 : segc[d]},
                              {48'd0, 4'h0, el,   (el == 4'd0) ? 8'h00 : es});
                    end
                end
                samp = 0; shape_bad = 1'b0;
                for (int d = 0; d < 4; d++) begin lit[d] = 0; segc[d] = 8'hFF; end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fs();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk100MHZ);
            if (bus.frame_start === 1'b1) found = 1'b1;
        end
        if (!found) check("frame_start_timeout", 64'd0, 64'd1);
    endtask

    task automatic drive(input ld_t d);
        bus.dig      = d.dig;
        bus.dp       = d.dp;
        bus.blink_en = d.bl;
        bus.load     = 1'b1;
    endtask

    task automatic run_row(input row_t r);
        wait_fs();
        bus.load       = 1'b0;
        bus.brightness = r.br;
        sb_q.push_back(r.ex);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk100MHZ);
            bus.load = 1'b0;
            if (int'(r.ja) == j)      drive(r.da);
            else if (int'(r.jb) == j) drive(r.db);
        end
    endtask

    task automatic reset_mid();
        wait_fs();
        bus.load = 1'b0;
        repeat (6) @(negedge clk100MHZ);
        check("pre_rst_an",  64'(bus.AN),  64'h0D);
        check("pre_rst_seg", 64'(bus.SEG), 64'h30);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_an",  64'(bus.AN),          64'h0F);
        check("mid_rst_seg", 64'(bus.SEG),         64'hFF);
        check("mid_rst_fs",  64'(bus.frame_start), 64'h0);
        repeat (2) @(negedge clk100MHZ);
        rst_n = 1'b1;
    endtask

    initial begin
        ld_t d1, dc, d3, z;
        z  = '0;
        d1 = '{dig: {5'd8, 5'd16, 5'd10, 5'd0}, dp: 4'b0001, bl: 4'b0000};
        d3 = uni(5'd3, 4'b1010, 4'b0100);
        dc = '{dig: {5'd15, 5'd14, 5'd13, 5'd12}, dp: 4'b0000, bl: 4'b0000};

        rows[0]  = mk(3'd7, 5,  d1,               0,  z,                32'hFFFFFFFF, 16'h4444);
        rows[1]  = mk(3'd7, 3,  uni(5'd1, 0, 0),  9,  uni(5'd2, 0, 0),  32'h80BF8840, 16'h4444);
        rows[2]  = mk(3'd7, 4,  uni(5'd7, 0, 0),  15, uni(5'd5, 0, 0),  32'hA4A4A4A4, 16'h4444);
        rows[3]  = mk(3'd7, 0,  z,                0,  z,                32'h92929292, 16'h4444);
        rows[4]  = mk(3'd0, 0,  z,                0,  z,                32'h92929292, 16'h0101);
        rows[5]  = mk(3'd3, 0,  z,                0,  z,                32'h92929292, 16'h0404);
        rows[6]  = mk(3'd5, 0,  z,                0,  z,                32'h92929292, 16'h2424);
        rows[7]  = mk(3'd7, 2,  d3,               0,  z,                32'h92929292, 16'h4444);
        rows[8]  = mk(3'd7, 0,  z,                0,  z,                32'h30B030B0, 16'h4444);
        rows[9]  = mk(3'd7, 0,  z,                0,  z,                32'h30B030B0, 16'h4044);
        rows[10] = mk(3'd7, 0,  z,                0,  z,                32'h30B030B0, 16'h4044);
        rows[11] = mk(3'd7, 0,  z,                0,  z,                32'h30B030B0, 16'h4444);
        rows[12] = mk(3'd7, 0,  z,                0,  z,                32'hFFFFFFFF, 16'h4444);
        rows[13] = mk(3'd7, 7,  dc,               0,  z,                32'hFFFFFFFF, 16'h4444);
        rows[14] = mk(3'd7, 0,  z,                0,  z,                32'h8E86A1C6, 16'h4444);

        rst_n          = 1'b0;
        bus.dig        = '0;
        bus.dp         = '0;
        bus.blink_en   = '0;
        bus.brightness = 3'd7;
        bus.load       = 1'b0;

        repeat (2) @(negedge clk100MHZ);
        check("rst_an",  64'(bus.AN),          64'h0F);
        check("rst_seg", 64'(bus.SEG),         64'hFF);
        check("rst_fs",  64'(bus.frame_start), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (i == 12) reset_mid();
            run_row(rows[i]);
        end

        wait_fs();
        repeat (2) @(negedge clk100MHZ);
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
